// File: rtl/vsync_pattern_pkg.sv
// Shared types for the vsync test-pattern source.
// Pattern select encoding and the colour-bar on/off table.
package vsync_pattern_pkg;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_GRID  = 2'd1,
        PAT_GRAD  = 2'd2,
        PAT_SOLID = 2'd3
    } pattern_e;

    localparam int unsigned BAR_COLOURS = 8;

    // {R,G,B} on/off per bar: white, yellow, cyan, green,
    // magenta, red, blue, black.
    localparam logic [2:0] BAR_MASK [BAR_COLOURS] = '{
        3'b111, 3'b110, 3'b011, 3'b010,
        3'b101, 3'b100, 3'b001, 3'b000
    };

    function automatic logic [2:0] bar_mask(input logic [2:0] idx);
        return BAR_MASK[idx];
    endfunction

endpackage

// File: rtl/vsync_pattern_generator_if.sv
// Video stream bundle between the sync generator, this
// pattern stage and the downstream encoder.
interface vsync_pattern_generator_if #(
    parameter int COMPONENT_WIDTH = 8
);
    logic                         in_vsync;
    logic                         in_hsync;
    logic                         in_de;
    logic                         out_vsync;
    logic                         out_hsync;
    logic                         out_de;
    logic [3*COMPONENT_WIDTH-1:0] out_data;

    modport master (
        output in_vsync, in_hsync, in_de,
        input  out_vsync, out_hsync, out_de, out_data
    );

    modport slave (
        input  in_vsync, in_hsync, in_de,
        output out_vsync, out_hsync, out_de, out_data
    );
endinterface

// File: rtl/vsync_pattern_timing.sv
// Stage 0: sync normalisation, edge detect, x/y counters, shadow params.
// VSYNC_PATTERN_SCROLL_EN adds a per-frame counter for horizontal scroll.
module vsync_pattern_timing
    import vsync_pattern_pkg::*;
#(
    parameter int H_COUNTER_WIDTH = 12,
    parameter int V_COUNTER_WIDTH = 12,
    parameter int COMPONENT_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         vsync_i,
    input  logic                         hsync_i,
    input  logic                         de_i,
    input  logic                         hsync_pol_i,
    input  logic                         vsync_pol_i,
    input  pattern_e                     pattern_i,
    input  logic [3*COMPONENT_WIDTH-1:0] solid_i,
    output logic                         vsn_o,
    output logic                         hsn_o,
    output logic                         de_o,
    output logic [H_COUNTER_WIDTH-1:0]   x_o,
    output logic [COMPONENT_WIDTH-1:0]   y_lo_o,
    output logic [H_COUNTER_WIDTH-1:0]   frame_o,
    output pattern_e                     pattern_o,
    output logic [3*COMPONENT_WIDTH-1:0] solid_o
);

    localparam logic [H_COUNTER_WIDTH-1:0] X_ONE = 1;
    localparam logic [V_COUNTER_WIDTH-1:0] Y_ONE = 1;

    logic                         vsn_q, vsn_d;
    logic                         hsn_q, hsn_d;
    logic                         de_q;
    logic                         vs_start;
    logic                         de_fall;
    logic [H_COUNTER_WIDTH-1:0]   x_q, x_d;
    logic [V_COUNTER_WIDTH-1:0]   y_q, y_d;
    pattern_e                     pattern_q, pattern_d;
    logic [3*COMPONENT_WIDTH-1:0] solid_q, solid_d;

    // Normalise polarity, find frame/line edges, step the counters.
    always_comb begin
        vsn_d     = vsync_i ^ ~vsync_pol_i;
        hsn_d     = hsync_i ^ ~hsync_pol_i;
        vs_start  = vsn_d & ~vsn_q;
        de_fall   = ~de_i & de_q;
        x_d       = (de_i & de_q) ? x_q + X_ONE : '0;
        y_d       = y_q;
        pattern_d = pattern_q;
        solid_d   = solid_q;
        if (de_fall) begin
            y_d = y_q + Y_ONE;
        end
        if (vs_start) begin
            y_d       = '0;
            pattern_d = pattern_i;
            solid_d   = solid_i;
        end
    end

    // Stage-0 pixel state and per-frame shadow parameters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vsn_q     <= 1'b0;
            hsn_q     <= 1'b0;
            de_q      <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            pattern_q <= PAT_BARS;
            solid_q   <= '0;
        end else begin
            vsn_q     <= vsn_d;
            hsn_q     <= hsn_d;
            de_q      <= de_i;
            x_q       <= x_d;
            y_q       <= y_d;
            pattern_q <= pattern_d;
            solid_q   <= solid_d;
        end
    end

`ifdef VSYNC_PATTERN_SCROLL_EN
    logic [H_COUNTER_WIDTH-1:0] frame_q, frame_d;

    // Frame count advances once per vsync start; it is the scroll offset.
    always_comb begin
        frame_d = vs_start ? frame_q + X_ONE : frame_q;
    end

    // Frame counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_q <= '0;
        end else begin
            frame_q <= frame_d;
        end
    end

    assign frame_o = frame_q;
`else
    assign frame_o = '0;
`endif

    assign vsn_o     = vsn_q;
    assign hsn_o     = hsn_q;
    assign de_o      = de_q;
    assign x_o       = x_q;
    assign y_lo_o    = y_q[COMPONENT_WIDTH-1:0];
    assign pattern_o = pattern_q;
    assign solid_o   = solid_q;

endmodule

// File: rtl/vsync_pattern_generator.sv
// Test-pattern pixel source: 2-clock pipeline from sync input to RGB out.
// VSYNC_PATTERN_SCROLL_EN enables 1 pixel/frame scroll of bars/gradient.
module vsync_pattern_generator
    import vsync_pattern_pkg::*;
#(
    parameter int H_COUNTER_WIDTH = 12,
    parameter int V_COUNTER_WIDTH = 12,
    parameter int COMPONENT_WIDTH = 8,
    parameter int BAR_SHIFT       = 7,
    parameter int GRID_SHIFT      = 5
) (
    input  logic                         clk,
    input  logic                         reset_n,
    vsync_pattern_generator_if.slave     vid,
    input  logic                         param_hsync_pol,
    input  logic                         param_vsync_pol,
    input  logic [1:0]                   param_pattern,
    input  logic [3*COMPONENT_WIDTH-1:0] param_solid_rgb
);

    localparam int CW = COMPONENT_WIDTH;
    localparam int PW = 3 * COMPONENT_WIDTH;
    localparam logic [H_COUNTER_WIDTH-1:0] LAST_BAR = H_COUNTER_WIDTH'(BAR_COLOURS - 1);

    logic                       vsn0, hsn0, de0;
    logic [H_COUNTER_WIDTH-1:0] x0, frame0;
    logic [CW-1:0]              y0;
    pattern_e                   pat0;
    logic [PW-1:0]              solid0;

    logic [H_COUNTER_WIDTH-1:0] x_eff;
    logic [H_COUNTER_WIDTH-1:0] bar_sel;
    logic [2:0]                 bar_idx;
    logic [2:0]                 mask;
    logic                       on_grid;
    logic [PW-1:0]              pix;

    logic          vsync_q, vsync_d;
    logic          hsync_q, hsync_d;
    logic          de_q;
    logic [PW-1:0] data_q, data_d;

    vsync_pattern_timing #(
        .H_COUNTER_WIDTH (H_COUNTER_WIDTH),
        .V_COUNTER_WIDTH (V_COUNTER_WIDTH),
        .COMPONENT_WIDTH (COMPONENT_WIDTH)
    ) u_timing (
        .clk         (clk),
        .reset_n     (reset_n),
        .vsync_i     (vid.in_vsync),
        .hsync_i     (vid.in_hsync),
        .de_i        (vid.in_de),
        .hsync_pol_i (param_hsync_pol),
        .vsync_pol_i (param_vsync_pol),
        .pattern_i   (pattern_e'(param_pattern)),
        .solid_i     (param_solid_rgb),
        .vsn_o       (vsn0),
        .hsn_o       (hsn0),
        .de_o        (de0),
        .x_o         (x0),
        .y_lo_o      (y0),
        .frame_o     (frame0),
        .pattern_o   (pat0),
        .solid_o     (solid0)
    );

    // Pattern mux for the stage-0 pixel.
    always_comb begin
        x_eff   = x0 + frame0;
        bar_sel = x_eff >> BAR_SHIFT;
        bar_idx = (bar_sel > LAST_BAR) ? 3'd7 : bar_sel[2:0];
        mask    = bar_mask(bar_idx);
        on_grid = (x0[GRID_SHIFT-1:0] == '0) ||
                  (y0[GRID_SHIFT-1:0] == '0);
        pix     = '0;
        unique case (pat0)
            PAT_BARS:  pix = {{CW{mask[2]}}, {CW{mask[1]}}, {CW{mask[0]}}};
            PAT_GRID:  pix = on_grid ? '1 : '0;
            PAT_GRAD:  pix = {x_eff[CW-1:0], y0, frame0[CW-1:0]};
            PAT_SOLID: pix = solid0;
            default:   pix = '0;
        endcase
    end

    // Restore sync polarity and blank data outside the active area.
    always_comb begin
        vsync_d = vsn0 ^ ~param_vsync_pol;
        hsync_d = hsn0 ^ ~param_hsync_pol;
        data_d  = de0 ? pix : '0;
    end

    // Stage-1 output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_q <= 1'b0;
            hsync_q <= 1'b0;
            de_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            vsync_q <= vsync_d;
            hsync_q <= hsync_d;
            de_q    <= de0;
            data_q  <= data_d;
        end
    end

    assign vid.out_vsync = vsync_q;
    assign vid.out_hsync = hsync_q;
    assign vid.out_de    = de_q;
    assign vid.out_data  = data_q;

endmodule
